// File: rtl/mure_pkg.sv
// Shared widths, entry structs and lane helpers for the compact retirement serializer.
package mure_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned IRETIRE_LEN    = 7;
  localparam int unsigned ITYPE_LEN      = 3;
  localparam int unsigned CAUSE_LEN      = 5;
  localparam int unsigned PRIV_LEN       = 2;

  localparam int unsigned DEF_NR_RETIRED = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;

  // Lane index width; a single lane still gets a 1-bit index.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Non-fall-through FIFO with the common_cells fifo_v3 port names (subset), power-of-two depth.
module fifo_v3 #(
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [31:0],
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  dtype                  r_mem [DEPTH];
  logic [ADDR_DEPTH-1:0] r_wr;
  logic [ADDR_DEPTH-1:0] r_rd;
  logic [ADDR_DEPTH:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign full_o    = (r_count == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign usage_o   = r_count[ADDR_DEPTH-1:0];
  assign data_o    = r_mem[r_rd];
  assign w_push_ok = push_i && !full_o;
  assign w_pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the serializer never exposes an empty head.
  always_ff @(posedge clk_i) begin
    if (w_push_ok && !flush_i) r_mem[r_wr] <= data_i;
  end

endmodule

// File: rtl/mure_lane_select.sv
// Picks the lowest valid lane at or above the pointer and flags whether it is the block's last one.
module mure_lane_select
  import mure_pkg::*;
#(
  parameter int unsigned NrLanes = DEF_NR_RETIRED
) (
  input  logic [NrLanes-1:0]         mask_i,
  input  logic [lane_w(NrLanes)-1:0] ptr_i,
  output logic [lane_w(NrLanes)-1:0] sel_o,
  output logic                       found_o,
  output logic                       is_last_o
);

  localparam int unsigned LaneW = lane_w(NrLanes);

  logic w_above;

  always_comb begin
    sel_o     = '0;
    found_o   = 1'b0;
    w_above   = 1'b0;
    is_last_o = 1'b0;
    for (int i = 0; i < NrLanes; i++) begin
      if (!found_o && mask_i[i] && (i >= int'(ptr_i))) begin
        found_o = 1'b1;
        sel_o   = LaneW'(i);
      end
    end
    for (int i = 0; i < NrLanes; i++) begin
      if (found_o && mask_i[i] && (i > int'(sel_o))) w_above = 1'b1;
    end
    is_last_o = found_o && !w_above;
  end

endmodule

// File: rtl/mure_compact_serializer.sv
// Buffers retirement blocks and emits only retired lanes, one per beat.
// Optional MURE_DROP_CNT_EN adds a saturating dropped-block counter (dropped_o).
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | FIFO empty, no beat offered, lane pointer at 0
// ST_SERIAL | head block being emitted, lane pointer = next lane to scan
module mure_compact_serializer
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = DEF_NR_RETIRED,
  parameter int unsigned FifoDepth      = DEF_FIFO_DEPTH
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic [NrRetiredInstr-1:0][IRETIRE_LEN-1:0] iretire_i,
  input  logic [NrRetiredInstr-1:0]                  ilastsize_i,
  input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]   itype_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]        iaddr_i,
  input  logic [CAUSE_LEN-1:0]                       cause_i,
  input  logic [XLEN-1:0]                            tval_i,
  input  logic [PRIV_LEN-1:0]                        priv_i,
  output logic                                       ready_o,
`ifdef MURE_DROP_CNT_EN
  output logic [15:0]                                dropped_o,
`endif
  output logic                                       valid_o,
  input  logic                                       ready_i,
  output logic                                       last_o,
  output logic [lane_w(NrRetiredInstr)-1:0]          lane_o,
  output logic [IRETIRE_LEN-1:0]                     iretire_o,
  output logic                                       ilastsize_o,
  output logic [ITYPE_LEN-1:0]                       itype_o,
  output logic [XLEN-1:0]                            iaddr_o,
  output logic [CAUSE_LEN-1:0]                       cause_o,
  output logic [XLEN-1:0]                            tval_o,
  output logic [PRIV_LEN-1:0]                        priv_o
);

  localparam int unsigned LaneW = lane_w(NrRetiredInstr);
  localparam int unsigned AddrW = $clog2(FifoDepth);

  typedef struct packed {
    uop_entry_s [NrRetiredInstr-1:0] uop;
    common_entry_s                   common;
    logic [NrRetiredInstr-1:0]       mask;
  } block_entry_s;

  block_entry_s     w_in;
  block_entry_s     w_head;
  logic             w_any_valid;
  logic             w_full;
  logic             w_empty;
  logic [AddrW-1:0] w_usage;
  logic             w_push;
  logic             w_pop;
  logic             w_fire;
  logic             w_valid;
  logic             w_last_block;
  logic [LaneW-1:0] w_sel;
  logic             w_found;
  logic             w_is_last;

  ser_state_e       r_state;
  logic [LaneW-1:0] r_ptr;

  always_comb begin
    w_in = '0;
    for (int i = 0; i < NrRetiredInstr; i++) begin
      w_in.mask[i]          = |iretire_i[i];
      w_in.uop[i].itype     = itype_i[i];
      w_in.uop[i].iaddr     = iaddr_i[i];
      w_in.uop[i].iretire   = iretire_i[i];
      w_in.uop[i].ilastsize = ilastsize_i[i];
    end
    w_in.common.cause = cause_i;
    w_in.common.tval  = tval_i;
    w_in.common.priv  = priv_i;
  end

  assign w_any_valid  = |w_in.mask;
  assign w_push       = w_any_valid && !w_full && !flush_i;
  assign w_valid      = (r_state == ST_SERIAL) && !w_empty && w_found;
  assign w_fire       = w_valid && ready_i && !flush_i;
  assign w_pop        = w_fire && w_is_last;
  assign w_last_block = (w_usage == AddrW'(1)) && !w_full;
  assign ready_o      = !w_full;
  assign valid_o      = w_valid;

  fifo_v3 #(
    .DEPTH (FifoDepth),
    .dtype (block_entry_s)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .full_o  (w_full),
    .empty_o (w_empty),
    .usage_o (w_usage),
    .data_i  (w_in),
    .push_i  (w_push),
    .data_o  (w_head),
    .pop_i   (w_pop)
  );

  mure_lane_select #(
    .NrLanes (NrRetiredInstr)
  ) u_lane_select (
    .mask_i    (w_head.mask),
    .ptr_i     (r_ptr),
    .sel_o     (w_sel),
    .found_o   (w_found),
    .is_last_o (w_is_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) r_state <= ST_SERIAL;
        end
        ST_SERIAL: begin
          if (w_fire) begin
            if (w_is_last) begin
              r_ptr <= '0;
              // Stay serial when another block remains or one lands this cycle.
              if (w_last_block && !w_push) r_state <= ST_IDLE;
            end else begin
              r_ptr <= w_sel + LaneW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Head and pointer only move on a handshake, so a stalled beat holds stable.
  always_comb begin
    last_o      = 1'b0;
    lane_o      = '0;
    iretire_o   = '0;
    ilastsize_o = 1'b0;
    itype_o     = '0;
    iaddr_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    if (w_valid) begin
      last_o      = w_is_last;
      lane_o      = w_sel;
      iretire_o   = w_head.uop[w_sel].iretire;
      ilastsize_o = w_head.uop[w_sel].ilastsize;
      itype_o     = w_head.uop[w_sel].itype;
      iaddr_o     = w_head.uop[w_sel].iaddr;
      cause_o     = w_head.common.cause;
      tval_o      = w_head.common.tval;
      priv_o      = w_head.common.priv;
    end
  end

`ifdef MURE_DROP_CNT_EN
  logic [15:0] r_dropped;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dropped <= '0;
    end else if (flush_i) begin
      r_dropped <= '0;
    end else if (w_any_valid && w_full && (r_dropped != 16'hFFFF)) begin
      r_dropped <= r_dropped + 16'd1;
    end
  end

  assign dropped_o = r_dropped;
`endif

endmodule

// File: tb/tb_mure_compact_serializer.sv
// Directed self-checking bench for mure_compact_serializer (2-lane and 4-lane instances).
module tb_mure_compact_serializer;

  logic clk;
  logic rst_n;
  logic flush;
  logic rdy;

  logic [1:0][6:0]  iret;
  logic [1:0]       ils;
  logic [1:0][2:0]  ityp;
  logic [1:0][63:0] iad;
  logic [4:0]       cause;
  logic [63:0]      tval;
  logic [1:0]       priv;

  logic        ready_w, valid_w, last_w;
  logic        lane_w;
  logic [6:0]  iret_o;
  logic        ils_o;
  logic [2:0]  ityp_o;
  logic [63:0] iad_o;
  logic [4:0]  cause_o;
  logic [63:0] tval_o;
  logic [1:0]  priv_o;

  logic [3:0][6:0]  iret4;
  logic [3:0]       ils4;
  logic [3:0][2:0]  ityp4;
  logic [3:0][63:0] iad4;
  logic        ready4, valid4, last4;
  logic [1:0]  lane4;
  logic [6:0]  iret4_o;
  logic        ils4_o;
  logic [2:0]  ityp4_o;
  logic [63:0] iad4_o;
  logic [4:0]  cause4_o;
  logic [63:0] tval4_o;
  logic [1:0]  priv4_o;
`ifdef MURE_DROP_CNT_EN
  logic [15:0] dropped_w;
  logic [15:0] dropped4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mure_compact_serializer #(.NrRetiredInstr(2), .FifoDepth(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .iretire_i(iret), .ilastsize_i(ils), .itype_i(ityp), .iaddr_i(iad),
    .cause_i(cause), .tval_i(tval), .priv_i(priv),
    .ready_o(ready_w),
`ifdef MURE_DROP_CNT_EN
    .dropped_o(dropped_w),
`endif
    .valid_o(valid_w), .ready_i(rdy), .last_o(last_w), .lane_o(lane_w),
    .iretire_o(iret_o), .ilastsize_o(ils_o), .itype_o(ityp_o), .iaddr_o(iad_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o)
  );

  mure_compact_serializer #(.NrRetiredInstr(4), .FifoDepth(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .iretire_i(iret4), .ilastsize_i(ils4), .itype_i(ityp4), .iaddr_i(iad4),
    .cause_i(cause), .tval_i(tval), .priv_i(priv),
    .ready_o(ready4),
`ifdef MURE_DROP_CNT_EN
    .dropped_o(dropped4),
`endif
    .valid_o(valid4), .ready_i(1'b1), .last_o(last4), .lane_o(lane4),
    .iretire_o(iret4_o), .ilastsize_o(ils4_o), .itype_o(ityp4_o), .iaddr_o(iad4_o),
    .cause_o(cause4_o), .tval_o(tval4_o), .priv_o(priv4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane 0 carries iretire 1 / itype 4 / lastsize 0, lane 1 carries 3 / 5 / 1.
  task automatic set_blk2(input logic [1:0] mask, input logic [63:0] a0, input logic [63:0] a1);
    iret[0] = mask[0] ? 7'd1 : 7'd0;
    iret[1] = mask[1] ? 7'd3 : 7'd0;
    ils     = 2'b10;
    ityp[0] = 3'd4;
    ityp[1] = 3'd5;
    iad[0]  = a0;
    iad[1]  = a1;
  endtask

  task automatic clr2();
    iret = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; rdy = 1'b0;
    iret = '0; ils = '0; ityp = '0; iad = '0;
    iret4 = '0; ils4 = '0; ityp4 = '0; iad4 = '0;
    cause = 5'd3; tval = 64'hDEAD; priv = 2'd1;
    tick(); tick();
    chk("rst_valid", valid_w, 0);
    chk("rst_last", last_w, 0);
    chk("rst_lane", lane_w, 0);
    chk("rst_iaddr", iad_o, 0);
    chk("rst_cause", cause_o, 0);
    chk("rst_ready", ready_w, 1);
    rst_n = 1'b1;
    tick();

    // Two-lane block, full mask, encoder always ready.
    rdy = 1'b1;
    set_blk2(2'b11, 64'h100, 64'h104);
    tick(); clr2();
    chk("t1_b0_valid", valid_w, 1);
    chk("t1_b0_lane", lane_w, 0);
    chk("t1_b0_addr", iad_o, 64'h100);
    chk("t1_b0_last", last_w, 0);
    chk("t1_b0_iret", iret_o, 1);
    chk("t1_b0_ityp", ityp_o, 4);
    chk("t1_b0_ils", ils_o, 0);
    chk("t1_b0_cause", cause_o, 3);
    chk("t1_b0_tval", tval_o, 64'hDEAD);
    chk("t1_b0_priv", priv_o, 1);
    tick();
    chk("t1_b1_valid", valid_w, 1);
    chk("t1_b1_lane", lane_w, 1);
    chk("t1_b1_addr", iad_o, 64'h104);
    chk("t1_b1_last", last_w, 1);
    chk("t1_b1_iret", iret_o, 3);
    chk("t1_b1_ityp", ityp_o, 5);
    chk("t1_b1_ils", ils_o, 1);
    tick();
    chk("t1_end_valid", valid_w, 0);
    chk("t1_end_addr", iad_o, 0);

    // All-invalid block is never pushed; lone upper lane is skipped to directly.
    tick();
    chk("zero_blk_valid", valid_w, 0);
    set_blk2(2'b10, 64'h700, 64'h704);
    tick(); clr2();
    chk("skip_lane", lane_w, 1);
    chk("skip_addr", iad_o, 64'h704);
    chk("skip_last", last_w, 1);
    tick();
    chk("skip_end", valid_w, 0);

    // Four-lane instance, mask 1010.
    iret4[1] = 7'd2; iret4[3] = 7'd4;
    iad4 = {64'h1C, 64'h18, 64'h14, 64'h10};
    tick(); iret4 = '0;
    chk("n4_b0_valid", valid4, 1);
    chk("n4_b0_lane", lane4, 1);
    chk("n4_b0_addr", iad4_o, 64'h14);
    chk("n4_b0_last", last4, 0);
    chk("n4_b0_iret", iret4_o, 2);
    tick();
    chk("n4_b1_lane", lane4, 3);
    chk("n4_b1_addr", iad4_o, 64'h1C);
    chk("n4_b1_last", last4, 1);
    chk("n4_b1_iret", iret4_o, 4);
    tick();
    chk("n4_end_valid", valid4, 0);

    // Fill 16 blocks under stall, drop a 17th, then drain without bubbles.
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fill_ready_15", ready_w, 1);
      set_blk2(2'b11, 64'h1000 + 64'(i * 16), 64'h1008 + 64'(i * 16));
      tick();
      chk("stall_valid", valid_w, 1);
      chk("stall_addr", iad_o, 64'h1000);
      chk("stall_lane", lane_w, 0);
    end
    chk("full_ready", ready_w, 0);
    set_blk2(2'b11, 64'h9990, 64'h9998);
    tick(); clr2();
    chk("drop_ready", ready_w, 0);
    chk("drop_stall_addr", iad_o, 64'h1000);
`ifdef MURE_DROP_CNT_EN
    chk("drop_count", dropped_w, 1);
`endif
    rdy = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int l = 0; l < 2; l++) begin
        chk("drain_valid", valid_w, 1);
        chk("drain_addr", iad_o, 64'h1000 + 64'(b * 16 + l * 8));
        chk("drain_last", last_w, (l == 1) ? 64'd1 : 64'd0);
        tick();
      end
    end
    chk("drain_end", valid_w, 0);
    chk("drain_ready", ready_w, 1);

    // Three blocks released together: six beats back to back.
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_blk2(2'b11, 64'h2000 + 64'(i * 16), 64'h2008 + 64'(i * 16));
      tick();
    end
    clr2();
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("b2b_valid", valid_w, 1);
      chk("b2b_addr", iad_o, 64'h2000 + 64'((k / 2) * 16 + (k % 2) * 8));
      chk("b2b_last", last_w, (k % 2 == 1) ? 64'd1 : 64'd0);
      tick();
    end
    chk("b2b_end", valid_w, 0);

    // Flush on the second beat with a same-cycle push.
    set_blk2(2'b11, 64'h200, 64'h204);
    tick(); clr2();
    chk("fl_b0_addr", iad_o, 64'h200);
    tick();
    chk("fl_b1_lane", lane_w, 1);
    flush = 1'b1;
    set_blk2(2'b11, 64'h300, 64'h304);
    tick(); flush = 1'b0; clr2();
    chk("fl_valid", valid_w, 0);
    chk("fl_ready", ready_w, 1);
`ifdef MURE_DROP_CNT_EN
    chk("fl_drop_clr", dropped_w, 0);
`endif
    tick(); tick();
    chk("fl_no_push", valid_w, 0);
    set_blk2(2'b01, 64'h400, 64'h404);
    tick(); clr2();
    chk("fl_after_addr", iad_o, 64'h400);
    chk("fl_after_last", last_w, 1);
    tick();
    chk("fl_after_end", valid_w, 0);

    // Asynchronous reset mid-block.
    set_blk2(2'b11, 64'h500, 64'h504);
    tick(); clr2();
    chk("rs_b0_addr", iad_o, 64'h500);
    tick();
    chk("rs_b1_lane", lane_w, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", valid_w, 0);
    chk("rs_async_lane", lane_w, 0);
    chk("rs_async_addr", iad_o, 0);
    chk("rs_async_ready", ready_w, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_blk2(2'b11, 64'h600, 64'h604);
    tick(); clr2();
    chk("rs_new_lane", lane_w, 0);
    chk("rs_new_addr", iad_o, 64'h600);
    chk("rs_new_last", last_w, 0);
    tick();
    chk("rs_new_b1", iad_o, 64'h604);
    chk("rs_new_b1_last", last_w, 1);
    tick();
    chk("rs_new_end", valid_w, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
